// File: rtl/lxp32_sram_ctrl.sv
// Wishbone-classic slave driving one port of an SRAM2RW-style macro; every pin is a flop output.
// Ack in cycle 4 for reads/full writes, cycle 7 for partial-write RMW, cycle 1 for sel=0 writes.
module lxp32_sram_ctrl #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [DATA_W/8-1:0]   wbs_sel_i,
    input  logic [ADDR_W-1:0]     wbs_adr_i,
    input  logic [DATA_W-1:0]     wbs_dat_i,
    output logic [DATA_W-1:0]     wbs_dat_o,
    output logic                  wbs_ack_o,
    output logic [ADDR_W-1:0]     sram_a_o,
    output logic                  sram_ce_o,
    output logic                  sram_csb_o,
    output logic                  sram_web_o,
    output logic                  sram_oeb_o,
    output logic [DATA_W-1:0]     sram_i_o,
    input  logic [DATA_W-1:0]     sram_o_i
);
    localparam int SEL_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE, R_SETUP, R_STROBE, R_HOLD, W_SETUP, W_STROBE, W_HOLD, ACK
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic                abort_q, abort_d;
    logic [ADDR_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   i_q, i_d;
    logic [DATA_W-1:0]   rdat_q, rdat_d;
    logic                ce_q, ce_d, csb_q, csb_d, web_q, web_d, oeb_q, oeb_d;
    logic                ack_q, ack_d;
    logic [DATA_W-1:0]   merged;

    always_comb begin
        merged = sram_o_i;
        for (int n = 0; n < SEL_W; n++) begin
            if (sel_q[n]) merged[8*n +: 8] = dat_q[8*n +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        a_d     = a_q;
        i_d     = i_q;
        rdat_d  = rdat_q;
        // Once cyc drops during a sequence, the sequence still finishes but is never acked.
        abort_d = abort_q | ~wbs_cyc_i;
        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (wbs_cyc_i && wbs_stb_i) begin
                    we_d  = wbs_we_i;
                    sel_d = wbs_sel_i;
                    dat_d = wbs_dat_i;
                    a_d   = wbs_adr_i;
                    if (!wbs_we_i) begin
                        state_d = R_SETUP;
                    end else if (wbs_sel_i == '1) begin
                        state_d = W_SETUP;
                        i_d     = wbs_dat_i;
                    end else if (wbs_sel_i == '0) begin
                        state_d = ACK;
                    end else begin
                        state_d = R_SETUP;
                    end
                end
            end
            R_SETUP:  state_d = R_STROBE;
            R_STROBE: state_d = R_HOLD;
            R_HOLD: begin
                if (we_q) begin
                    i_d     = merged;
                    state_d = W_SETUP;
                end else begin
                    rdat_d  = sram_o_i;
                    state_d = ACK;
                end
            end
            W_SETUP:  state_d = W_STROBE;
            W_STROBE: state_d = W_HOLD;
            W_HOLD:   state_d = ACK;
            default:  state_d = IDLE;
        endcase

        // Pin values are decoded from the next state so they land on flops.
        ce_d  = (state_d == R_STROBE) || (state_d == W_STROBE);
        csb_d = !(state_d inside {R_SETUP, R_STROBE, R_HOLD, W_SETUP, W_STROBE, W_HOLD});
        web_d = !(state_d inside {W_SETUP, W_STROBE, W_HOLD});
        oeb_d = !(state_d inside {R_SETUP, R_STROBE, R_HOLD});
        ack_d = (state_d == ACK) && wbs_cyc_i && !abort_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            abort_q <= 1'b0;
            a_q     <= '0;
            i_q     <= '0;
            rdat_q  <= '0;
            ce_q    <= 1'b0;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            oeb_q   <= 1'b1;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            abort_q <= abort_d;
            a_q     <= a_d;
            i_q     <= i_d;
            rdat_q  <= rdat_d;
            ce_q    <= ce_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            oeb_q   <= oeb_d;
            ack_q   <= ack_d;
        end
    end

    assign wbs_dat_o  = rdat_q;
    assign wbs_ack_o  = ack_q;
    assign sram_a_o   = a_q;
    assign sram_ce_o  = ce_q;
    assign sram_csb_o = csb_q;
    assign sram_web_o = web_q;
    assign sram_oeb_o = oeb_q;
    assign sram_i_o   = i_q;
endmodule

// File: tb/tb_lxp32_sram_ctrl.sv
// Directed bench for lxp32_sram_ctrl with a behavioural SRAM macro and a read-data scoreboard.
module tb_lxp32_sram_ctrl;
    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [6:0]  wbs_adr_i;
    logic [31:0] wbs_dat_i, wbs_dat_o;
    logic        wbs_ack_o;
    logic [6:0]  sram_a_o;
    logic        sram_ce_o, sram_csb_o, sram_web_o, sram_oeb_o;
    logic [31:0] sram_i_o, sram_o_i;

    always #5 clk_i = ~clk_i;

    lxp32_sram_ctrl #(.ADDR_W(7), .DATA_W(32)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
        .sram_a_o(sram_a_o), .sram_ce_o(sram_ce_o), .sram_csb_o(sram_csb_o),
        .sram_web_o(sram_web_o), .sram_oeb_o(sram_oeb_o),
        .sram_i_o(sram_i_o), .sram_o_i(sram_o_i)
    );

    // Macro model: acts on the CE rising edge, drives read data only while OEB is low.
    logic [31:0] mem [0:127];
    logic [31:0] dout = '0;
    int ce_cnt = 0;
    int ce_wr_cnt = 0;
    always @(posedge sram_ce_o) begin
        ce_cnt++;
        if (!sram_csb_o) begin
            if (!sram_web_o) begin
                mem[sram_a_o] = sram_i_o;
                ce_wr_cnt++;
            end else begin
                dout = mem[sram_a_o];
            end
        end
    end
    assign sram_o_i = sram_oeb_o ? 32'h0 : dout;

    logic [31:0] shadow [0:127];
    logic [31:0] exp_q [$];
    logic [31:0] last_rd = '0;
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ce"},  {31'd0, sram_ce_o},  32'd0);
        check({tag, "_csb"}, {31'd0, sram_csb_o}, 32'd1);
        check({tag, "_web"}, {31'd0, sram_web_o}, 32'd1);
        check({tag, "_oeb"}, {31'd0, sram_oeb_o}, 32'd1);
        check({tag, "_a"},   {25'd0, sram_a_o},   32'd0);
        check({tag, "_i"},   sram_i_o,            32'd0);
        check({tag, "_ack"}, {31'd0, wbs_ack_o},  32'd0);
        check({tag, "_dat"}, wbs_dat_o,           32'd0);
    endtask

    // Runs one bus access over a fixed 12-cycle window; cycle 0 is the cycle the request is presented.
    task automatic access(input logic we, input logic [3:0] sel, input logic [6:0] adr,
                          input logic [31:0] dat, input int exp_cyc, input int exp_ce,
                          input int exp_oeb, input int abort_at, input string tag);
        int ce0, wr0, oeb_cnt, ce_hi, ack_n, ack_cyc, exp_wr;
        logic [31:0] e;
        if (!we) begin
            exp_q.push_back(shadow[adr]);
            last_rd = shadow[adr];
        end else begin
            for (int n = 0; n < 4; n++)
                if (sel[n]) shadow[adr][8*n +: 8] = dat[8*n +: 8];
        end
        exp_wr = (we && sel != 4'h0) ? 1 : 0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = dat;
        ce0 = ce_cnt; wr0 = ce_wr_cnt;
        oeb_cnt = 0; ce_hi = 0; ack_n = 0; ack_cyc = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk_i); #1;
            if (!sram_oeb_o) oeb_cnt++;
            if (sram_ce_o) ce_hi++;
            if (k == abort_at) begin
                wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            end
            if (wbs_ack_o) begin
                ack_n++;
                if (ack_cyc < 0) begin
                    ack_cyc = k;
                    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
                    if (!we && exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check({tag, "_rdata"}, wbs_dat_o, e);
                    end
                end
            end
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_rdata_noack"}, 32'hDEAD_0000, e);
        end
        check({tag, "_ack_cycle"}, ack_cyc, exp_cyc);
        check({tag, "_ack_count"}, ack_n, (exp_cyc < 0) ? 0 : 1);
        check({tag, "_ce_pulses"}, ce_cnt - ce0, exp_ce);
        check({tag, "_ce_high_cycles"}, ce_hi, exp_ce);
        check({tag, "_write_pulses"}, ce_wr_cnt - wr0, exp_wr);
        check({tag, "_oeb_low_cycles"}, oeb_cnt, exp_oeb);
    endtask

    initial begin
        int ce0, ce_hi, ack_seen;
        rstn_i = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        rstn_i = 1'b1;
        ce0 = ce_cnt; ce_hi = 0; ack_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk_i); #1;
            if (sram_ce_o) ce_hi++;
            if (wbs_ack_o) ack_seen++;
        end
        check("idle_ce_high", ce_hi + (ce_cnt - ce0), 0);
        check("idle_ack", ack_seen, 0);
        check("idle_csb", {31'd0, sram_csb_o}, 32'd1);

        access(1'b1, 4'hF, 7'h05, 32'hDEADBEEF, 4, 1, 0, -1, "wr_full_05");
        access(1'b0, 4'h0, 7'h05, 32'h0,        4, 1, 3, -1, "rd_05");
        access(1'b1, 4'hF, 7'h00, 32'h0BADF00D, 4, 1, 0, -1, "wr_full_00");
        check("dat_o_kept_over_write", wbs_dat_o, last_rd);

        access(1'b1, 4'hF, 7'h7F, 32'h11223344, 4, 1, 0, -1, "wr_pre_7f");
        access(1'b1, 4'h5, 7'h7F, 32'hAABBCCDD, 7, 2, 3, -1, "rmw_7f");
        access(1'b0, 4'hF, 7'h7F, 32'h0,        4, 1, 3, -1, "rd_7f");
        check("rmw_merge_value", wbs_dat_o, 32'h11BB33DD);

        access(1'b1, 4'h0, 7'h05, 32'h12345678, 1, 0, 0, -1, "wr_sel0_05");
        access(1'b0, 4'h3, 7'h05, 32'h0,        4, 1, 3, -1, "rd_05_after_sel0");
        access(1'b0, 4'h0, 7'h00, 32'h0,        4, 1, 3, -1, "rd_00");

        access(1'b1, 4'h8, 7'h05, 32'h55000000, -1, 2, 3, 2, "rmw_abort_05");
        access(1'b0, 4'h0, 7'h05, 32'h0,        4, 1, 3, -1, "rd_05_after_abort");
        check("abort_write_half_value", wbs_dat_o, 32'h55ADBEEF);

        // Reset while the write strobe is high.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_sel_i = 4'hF; wbs_adr_i = 7'h10; wbs_dat_i = 32'h99999999;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check("wstrobe_ce_before_reset", {31'd0, sram_ce_o}, 32'd1);
        rstn_i = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge clk_i); #1;
        check_reset_outputs("mid_reset");
        rstn_i = 1'b1;
        @(posedge clk_i); #1;

        access(1'b1, 4'hF, 7'h10, 32'hCAFEF00D, 4, 1, 0, -1, "wr_after_reset");
        access(1'b0, 4'h0, 7'h10, 32'h0,        4, 1, 3, -1, "rd_after_reset");
        access(1'b0, 4'h0, 7'h7F, 32'h0,        4, 1, 3, -1, "rd_7f_again");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/lxp32_sram_ctrl.md
# lxp32_sram_ctrl

Wishbone-classic slave that acts as the initiator for one port of the dual-port SRAM macro (SRAM2RW-style: CE-edge sampled, active-low CSB/WEB/OEB, no byte enables). Sits between the CPU data/instruction bus and the SRAM macro port pins. It generates all macro control strobes from flops. Sub-word writes are implemented as read-modify-write.

## Interface
- ADDR_W, 7, word-address width; equals the macro address width.
- DATA_W, 32, word width; must be a multiple of 8. SEL_W = DATA_W/8.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  reset; synchronous, active-low
- wbs_cyc_i  in  1  bus cycle
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  1 = write
- wbs_sel_i  in  SEL_W  byte selects; bit n covers bits [8n+7:8n]
- wbs_adr_i  in  ADDR_W  word address
- wbs_dat_i  in  DATA_W  write data
- wbs_dat_o  out  DATA_W  read data, registered
- wbs_ack_o  out  1  one-cycle acknowledge
- sram_a_o  out  ADDR_W  macro address
- sram_ce_o  out  1  macro clock/strobe; the macro samples on its rising edge
- sram_csb_o  out  1  chip select, active-low
- sram_web_o  out  1  write enable, active-low
- sram_oeb_o  out  1  output enable, active-low
- sram_i_o  out  DATA_W  macro write data
- sram_o_i  in  DATA_W  macro read data

## Operation
- States: IDLE, R_SETUP, R_STROBE, R_HOLD, W_SETUP, W_STROBE, W_HOLD, ACK.
- IDLE: on cyc&stb, latch adr, we, sel and dat. Then branch:
  - read -> R_SETUP
  - write with sel all-ones -> W_SETUP
  - write with sel all-zero -> ACK, no SRAM access
  - other writes -> R_SETUP, then RMW
- R_SETUP: csb=0, web=1, oeb=0, ce=0, sram_a_o = latched address.
- R_STROBE: ce=1.
- R_HOLD: ce=0. At the end of the cycle, capture sram_o_i.
  - Plain read: the capture goes to wbs_dat_o; next state is ACK.
  - RMW: the capture goes to a merge register; next state is W_SETUP.
- Merge rule: for each byte n, use wbs_dat_i byte n if sel[n]=1, otherwise the read-back byte.
- W_SETUP: csb=0, web=0, oeb=1, ce=0, sram_i_o = write word (full or merged).
- W_STROBE: ce=1.
- W_HOLD: ce=0; csb, web and sram_i_o held.
- ACK:
  - csb=1, web=1, oeb=1.
  - wbs_ack_o=1 only if wbs_cyc_i=1 in this cycle.
  - Next state is IDLE.
  - stb is ignored in this state.
- Requests are ignored in every state except IDLE.
- Every sram_*_o and wbs_ack_o is a flop output, with no combinational decode to pins. sram_ce_o never glitches.
- A, I, CSB and WEB are stable for the whole setup, strobe and hold window around each CE rising edge.
- cyc deasserted mid-sequence:
  - A started CE pulse and its hold cycle always complete.
  - An RMW continues through its write half.
  - ACK is suppressed.
- Reads ignore sel. wbs_dat_o keeps its last value between reads and is not cleared by writes.

## Timing
- Reset (rstn_i=0 at a clk_i edge) drives the block to:
  - state IDLE
  - sram_ce_o=0, sram_csb_o=1, sram_web_o=1, sram_oeb_o=1
  - sram_a_o=0, sram_i_o=0
  - wbs_ack_o=0, wbs_dat_o=0
- Reset mid-sequence applies the same values at the next edge. A CE pulse may be truncated; the word at that address is then undefined.
- Let cycle 0 be the cycle in which IDLE samples cyc&stb. Acknowledge timing:
  - Read and full write: SRAM setup in cycle 1, ack in cycle 4.
  - Partial write: ack in cycle 7.
  - sel=0 write: ack in cycle 1.
- Read data is valid on wbs_dat_o in the ack cycle.
- Back-to-back requests: the next request is sampled in IDLE in the cycle after ack. Peak rate is 1 access per 5 cycles (8 for RMW).
- sram_ce_o high time is exactly 1 clk_i cycle. Low time between pulses is at least 2 cycles.

## Test plan
- Reset, then idle: all sram_* outputs at reset values; sram_ce_o stays 0 for 20 cycles; no ack.
- Full write, then read back:
  - Write adr=0x05, dat=0xDEADBEEF, sel=0xF: ack in cycle 4; exactly one CE pulse with web=0.
  - Read adr=0x05: wbs_dat_o=0xDEADBEEF at ack in cycle 4; oeb=0 only during the read states.
- RMW: preload 0x11223344 at 0x7F, then write dat=0xAABBCCDD with sel=0b0101.
  - Ack in cycle 7; two CE pulses.
  - Read back of 0x7F returns 0x11BB33DD.
- sel=0 write to a preloaded word: ack in cycle 1, no CE pulse, word unchanged.
- Abort: drop cyc in R_STROBE of an RMW.
  - The write half still completes.
  - No ack is issued.
  - A new request is accepted afterwards.
- Reset asserted during W_STROBE: outputs reach reset values at the next edge; the next access works normally. Also cover addresses 0x00 and 0x7F for address-range coverage.
